membus_arbiter: RTL and testbench
=================================

# membus_arbiter

Two-client, single-outstanding arbiter that shares one memory port between the core's instruction-fetch bus and data bus. It sits between the core and the memory/cache interconnect, latching the granted request, holding it stable downstream until the memory responds, and returning a one-cycle `data_ok` pulse with read data to the owning client. Round-robin arbitration stops either client starving the other when both are valid.

## Interface

- Parameters
  - `ADDR_W`, default 64: address width.
  - `DATA_W`, default 64: memory data width. Fixed at 64; the byte lanes below assume 8 strobes.
- Ports
  - `clk`: input, 1 bit. Clock.
  - `reset`: input, 1 bit. Asynchronous, active-high.
  - `i_valid`: input, 1 bit. Instruction-fetch request.
  - `i_addr`: input, ADDR_W bits. Fetch address, 4-byte aligned.
  - `i_data_ok`: output, 1 bit. One-cycle fetch completion pulse.
  - `i_data`: output, 32 bits. Fetched instruction word.
  - `d_valid`: input, 1 bit. Data request.
  - `d_addr`: input, ADDR_W bits. Data address.
  - `d_size`: input, 3 bits. Access size code: 0 = byte, 1 = half, 2 = word, 3 = double.
  - `d_strobe`: input, 8 bits. Byte-write enables. All zero means a read.
  - `d_wdata`: input, 64 bits. Write data, already lane-aligned.
  - `d_data_ok`: output, 1 bit. One-cycle data completion pulse.
  - `d_rdata`: output, 64 bits. Raw 64-bit read data, not shifted or extended.
  - `m_valid`: output, 1 bit. Downstream request valid.
  - `m_is_write`: output, 1 bit. Downstream write flag.
  - `m_addr`: output, ADDR_W bits. Downstream address.
  - `m_size`: output, 3 bits. Downstream access size code.
  - `m_strobe`: output, 8 bits. Downstream byte strobes.
  - `m_wdata`: output, 64 bits. Downstream write data.
  - `m_ready`: input, 1 bit. Downstream completion, a single-cycle pulse.
  - `m_rdata`: input, 64 bits. Downstream read data, valid while `m_ready` = 1.
  - `busy`: output, 1 bit. High whenever the FSM is not IDLE.
  - `owner`: output, 1 bit. Current or last grant: 0 = fetch, 1 = data.

## Operation

- **FSM states:** IDLE, REQ, RESP.
- **IDLE**
  - If no client is valid, stay in IDLE.
  - If exactly one client is valid, grant it.
  - If both are valid, grant the client that is not `last_owner`, then set `last_owner` to the winner.
  - On a grant, latch the downstream fields into registers and go to REQ.
- **Fetch latch:** `m_addr` = `i_addr`, `m_size` = 3'b010, `m_strobe` = 0, `m_is_write` = 0, `m_wdata` = 0.
- **Data latch:** `m_addr`, `m_size`, `m_strobe` and `m_wdata` are copied from the `d_*` inputs; `m_is_write` = OR of `d_strobe`.
- **REQ**
  - `m_valid` = 1 and all `m_*` fields are held constant.
  - Client inputs are ignored, including a client dropping `valid`; the latched transaction still completes.
  - On `m_ready`, register the response data and go to RESP.
- **Response data register**
  - Fetch owner: `i_data` ← `m_addr[2]` ? `m_rdata[63:32]` : `m_rdata[31:0]`.
  - Data owner: `d_rdata` ← `m_rdata`.
  - On writes, the `rdata` register is still loaded; its value is don't-care.
- **RESP**
  - The owner's `data_ok` = 1 for exactly this cycle. `m_valid` = 0.
  - Both clients' `valid` inputs are ignored this cycle, because a requester advances on this edge and its `valid` still reflects the finished request.
  - Next state is always IDLE.
- **Held outputs:** `i_data` and `d_rdata` hold their last value until the next completion for the same client.
- **Stray `m_ready`:** `m_ready` in IDLE or RESP is ignored.
- **Tie-break pointer:** `last_owner` resets to fetch, so the first contention goes to data.

## Timing

- **Reset values:** `m_valid`, `m_is_write`, `m_addr`, `m_size`, `m_strobe`, `m_wdata`, `i_data_ok`, `d_data_ok`, `i_data`, `d_rdata`, `busy` and `owner` are all 0. FSM = IDLE, `last_owner` = fetch.
- **Latency:**
  - Request sampled in IDLE at cycle t.
  - `m_valid` is high from cycle t+1.
  - `m_ready` arrives at cycle t+k, with k ≥ 1.
  - `data_ok` and data appear at cycle t+k+1.
  - Earliest next grant is sampled at cycle t+k+2.
  - Minimum occupancy is 3 cycles per transaction.
- **Output sources:** all outputs are registered or decoded from state. No combinational path runs from `m_ready` or the client inputs to any output.
- **Outstanding:** at most one transaction is in flight; there is no queueing.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs at their reset values in the same instant. The downstream transaction is abandoned and no `data_ok` is issued for it.
- **Contention:** a fetch and a data request that stay valid are served alternately, each starting 3 cycles apart when `m_ready` arrives at k = 1.

## Test plan

- **Reset then single fetch:** `i_valid` = 1, `i_addr` = 0x8000_0004, `m_ready` at k = 2 with `m_rdata` = 0x1111_2222_3333_4444 -> `m_size` = 2 and `m_strobe` = 0 during REQ; `i_data_ok` pulses one cycle with `i_data` = 0x1111_2222.
- **Data write:** `d_strobe` = 0x0F, `d_wdata` = 0xAABB_CCDD, `d_addr` = 0x8000_1000, `d_size` = 2 -> `m_is_write` = 1 with fields held stable for 5 cycles of stall; a single `d_data_ok` pulse follows; `i_data_ok` stays 0.
- **Simultaneous requests after reset:** both valid -> data is granted first, fetch second; `owner` sequence is 1, then 0; both `data_ok` pulses occur exactly once.
- **Requester holds `valid` through RESP:** `d_valid` stays high the cycle `d_data_ok` = 1 -> no duplicate `m_valid` issue. A new request is only granted if `d_valid` is still high the following IDLE cycle.
- **Reset mid-REQ:** assert `reset` 1 cycle after `m_valid` rises -> `m_valid` = 0 immediately and FSM = IDLE. A later `m_ready` pulse produces no `data_ok`.
- **Client drops `valid` in REQ:** `i_valid` is deasserted after the grant -> the transaction still completes and `i_data_ok` pulses once.

Source files
------------

// File: rtl/membus_arbiter.sv
// Round-robin, single-outstanding arbiter sharing one memory port between
// the instruction-fetch bus and the data bus.
module membus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_data_ok,
    output logic [31:0]       i_data,

    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_valid,
    output logic              m_is_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_owner;
    logic   contention;
    logic   grant_data;

    // On contention the client that did not win last time gets the port.
    always_comb begin
        contention = i_valid && d_valid;
        grant_data = d_valid && !(i_valid && last_owner);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            owner      <= 1'b0;
            m_valid    <= 1'b0;
            m_is_write <= 1'b0;
            m_addr     <= '0;
            m_size     <= 3'b000;
            m_strobe   <= 8'h00;
            m_wdata    <= '0;
            i_data_ok  <= 1'b0;
            i_data     <= 32'h0;
            d_data_ok  <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_data_ok <= 1'b0;
            d_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid || d_valid) begin
                        state   <= REQ;
                        m_valid <= 1'b1;
                        owner   <= grant_data;
                        if (contention) begin
                            last_owner <= grant_data;
                        end
                        if (grant_data) begin
                            m_addr     <= d_addr;
                            m_size     <= d_size;
                            m_strobe   <= d_strobe;
                            m_wdata    <= d_wdata;
                            m_is_write <= |d_strobe;
                        end else begin
                            m_addr     <= i_addr;
                            m_size     <= 3'b010;
                            m_strobe   <= 8'h00;
                            m_wdata    <= '0;
                            m_is_write <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    // Client inputs are ignored here; the latched request is held until m_ready.
                    if (m_ready) begin
                        state   <= RESP;
                        m_valid <= 1'b0;
                        if (owner) begin
                            d_rdata   <= m_rdata;
                            d_data_ok <= 1'b1;
                        end else begin
                            i_data    <= m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
                            i_data_ok <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Requesters still show the finished request's valid this cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_membus_arbiter.sv
// Table-driven cycle trace for membus_arbiter plus a hand-written
// asynchronous reset-during-request sequence.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_data_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_data_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic        m_is_write;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_ready;
    logic [63:0] m_rdata;
    logic        busy;
    logic        owner;

    always #5 clk = ~clk;

    membus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] da;
        logic [2:0]  ds;
        logic [7:0]  dst;
        logic [63:0] dw;
        logic        mr;
        logic [63:0] md;
    } ins_t;

    typedef struct packed {
        logic        mv;
        logic        mw;
        logic [63:0] ma;
        logic [2:0]  ms;
        logic [7:0]  mst;
        logic [63:0] mwd;
        logic        iok;
        logic [31:0] id;
        logic        dok;
        logic [63:0] dr;
        logic        bsy;
        logic        own;
    } outs_t;

    typedef struct {
        string name;
        ins_t  in;
        outs_t exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [63:0] Z64  = 64'h0;
    localparam logic [63:0] FA   = 64'h0000_0000_8000_0004;
    localparam logic [63:0] WA   = 64'h0000_0000_8000_1000;
    localparam logic [63:0] WD   = 64'h0000_0000_AABB_CCDD;
    localparam logic [63:0] CAFE = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] D55  = 64'h5555_AAAA_5555_AAAA;

    function automatic ins_t mk_in(input logic rst, input logic iv, input logic [63:0] ia,
                                   input logic dv, input logic [63:0] da, input logic [2:0] ds,
                                   input logic [7:0] dst, input logic [63:0] dw,
                                   input logic mr, input logic [63:0] md);
        ins_t r;
        r = '{rst, iv, ia, dv, da, ds, dst, dw, mr, md};
        return r;
    endfunction

    function automatic outs_t mk_out(input logic mv, input logic mw, input logic [63:0] ma,
                                     input logic [2:0] ms, input logic [7:0] mst,
                                     input logic [63:0] mwd, input logic iok, input logic [31:0] id,
                                     input logic dok, input logic [63:0] dr,
                                     input logic bsy, input logic own);
        outs_t r;
        r = '{mv, mw, ma, ms, mst, mwd, iok, id, dok, dr, bsy, own};
        return r;
    endfunction

    task automatic add(input string n, input ins_t i, input outs_t o);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input ins_t v);
        reset    = v.rst;
        i_valid  = v.iv;
        i_addr   = v.ia;
        d_valid  = v.dv;
        d_addr   = v.da;
        d_size   = v.ds;
        d_strobe = v.dst;
        d_wdata  = v.dw;
        m_ready  = v.mr;
        m_rdata  = v.md;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string n, input outs_t e);
        outs_t a;
        a = {m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
             i_data_ok, i_data, d_data_ok, d_rdata, busy, owner};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic check64(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    initial begin
        ins_t  in0;
        outs_t o;
        in0 = mk_in(1'b0, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, Z64);

        // Reset and a single fetch (upper word, k = 2, valid dropped in REQ).
        add("reset",     mk_in(1'b1, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, Z64),
                         mk_out(1'b0, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 32'h0, 1'b0, Z64, 1'b0, 1'b0));
        add("idle",      in0,
                         mk_out(1'b0, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 32'h0, 1'b0, Z64, 1'b0, 1'b0));
        o = mk_out(1'b1, 1'b0, FA, 3'd2, 8'h00, Z64, 1'b0, 32'h0, 1'b0, Z64, 1'b1, 1'b0);
        add("f_grant",   mk_in(1'b0, 1'b1, FA, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, Z64), o);
        add("f_drop",    in0, o);
        add("f_ready",   mk_in(1'b0, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, 64'h1111_2222_3333_4444),
                         mk_out(1'b0, 1'b0, FA, 3'd2, 8'h00, Z64, 1'b1, 32'h1111_2222, 1'b0, Z64, 1'b1, 1'b0));
        o = mk_out(1'b0, 1'b0, FA, 3'd2, 8'h00, Z64, 1'b0, 32'h1111_2222, 1'b0, Z64, 1'b0, 1'b0);
        add("f_idle",    in0, o);
        add("stray_rdy", mk_in(1'b0, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF), o);

        // Data write with 5 stall cycles; inputs change under the held request.
        o = mk_out(1'b1, 1'b1, WA, 3'd2, 8'h0F, WD, 1'b0, 32'h1111_2222, 1'b0, Z64, 1'b1, 1'b1);
        add("w_grant",   mk_in(1'b0, 1'b0, Z64, 1'b1, WA, 3'd2, 8'h0F, WD, 1'b0, Z64), o);
        for (int k = 0; k < 5; k++)
            add("w_stall", mk_in(1'b0, 1'b0, Z64, 1'b0, 64'hFFFF, 3'd3, 8'hFF, 64'h1234, 1'b0, Z64), o);
        add("w_ready",   mk_in(1'b0, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, Z64),
                         mk_out(1'b0, 1'b1, WA, 3'd2, 8'h0F, WD, 1'b0, 32'h1111_2222, 1'b1, Z64, 1'b1, 1'b1));
        add("w_idle",    in0,
                         mk_out(1'b0, 1'b1, WA, 3'd2, 8'h0F, WD, 1'b0, 32'h1111_2222, 1'b0, Z64, 1'b0, 1'b1));

        // Contention after reset: data first, then fetch (lower word).
        add("reset2",    mk_in(1'b1, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, Z64),
                         mk_out(1'b0, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 32'h0, 1'b0, Z64, 1'b0, 1'b0));
        add("both_gnt_d", mk_in(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 3'd3, 8'h00, Z64, 1'b0, Z64),
                         mk_out(1'b1, 1'b0, 64'h2000, 3'd3, 8'h00, Z64, 1'b0, 32'h0, 1'b0, Z64, 1'b1, 1'b1));
        add("both_rdy_d", mk_in(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 3'd3, 8'h00, Z64, 1'b1, CAFE),
                         mk_out(1'b0, 1'b0, 64'h2000, 3'd3, 8'h00, Z64, 1'b0, 32'h0, 1'b1, CAFE, 1'b1, 1'b1));
        add("both_resp", mk_in(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 3'd3, 8'h00, Z64, 1'b1, Z64),
                         mk_out(1'b0, 1'b0, 64'h2000, 3'd3, 8'h00, Z64, 1'b0, 32'h0, 1'b0, CAFE, 1'b0, 1'b1));
        add("both_gnt_f", mk_in(1'b0, 1'b1, 64'h1000, 1'b1, 64'h2000, 3'd3, 8'h00, Z64, 1'b0, Z64),
                         mk_out(1'b1, 1'b0, 64'h1000, 3'd2, 8'h00, Z64, 1'b0, 32'h0, 1'b0, CAFE, 1'b1, 1'b0));
        add("f_ready2",  mk_in(1'b0, 1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, 64'h9999_8888_7777_6666),
                         mk_out(1'b0, 1'b0, 64'h1000, 3'd2, 8'h00, Z64, 1'b1, 32'h7777_6666, 1'b0, CAFE, 1'b1, 1'b0));
        add("f_idle2",   in0,
                         mk_out(1'b0, 1'b0, 64'h1000, 3'd2, 8'h00, Z64, 1'b0, 32'h7777_6666, 1'b0, CAFE, 1'b0, 1'b0));

        // Data read whose requester holds valid through RESP: no duplicate issue.
        add("d_grant",   mk_in(1'b0, 1'b0, Z64, 1'b1, 64'h3008, 3'd1, 8'h00, Z64, 1'b0, Z64),
                         mk_out(1'b1, 1'b0, 64'h3008, 3'd1, 8'h00, Z64, 1'b0, 32'h7777_6666, 1'b0, CAFE, 1'b1, 1'b1));
        add("d_rdy_hold", mk_in(1'b0, 1'b0, Z64, 1'b1, 64'h3008, 3'd1, 8'h00, Z64, 1'b1, D55),
                         mk_out(1'b0, 1'b0, 64'h3008, 3'd1, 8'h00, Z64, 1'b0, 32'h7777_6666, 1'b1, D55, 1'b1, 1'b1));
        o = mk_out(1'b0, 1'b0, 64'h3008, 3'd1, 8'h00, Z64, 1'b0, 32'h7777_6666, 1'b0, D55, 1'b0, 1'b1);
        add("d_resp_hold", mk_in(1'b0, 1'b0, Z64, 1'b1, 64'h3008, 3'd1, 8'h00, Z64, 1'b0, Z64), o);
        add("d_no_dup",  in0, o);

        foreach (vecs[n]) begin
            drive(vecs[n].in);
            tick();
            check_vec($sformatf("v%0d_%s", n, vecs[n].name), vecs[n].exp);
        end

        // Reset one cycle after m_valid rises; the late m_ready must be ignored.
        drive(mk_in(1'b0, 1'b1, 64'h40, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, Z64));
        tick();
        check64("rst_req_mvalid", {63'h0, m_valid}, 64'h1);
        i_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check64("rst_async_mvalid", {63'h0, m_valid}, 64'h0);
        check64("rst_async_busy",   {63'h0, busy}, 64'h0);
        check64("rst_async_maddr",  m_addr, Z64);
        check64("rst_async_idata",  {32'h0, i_data}, Z64);
        check64("rst_async_drdata", d_rdata, Z64);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b1;
        m_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        m_ready = 1'b0;
        check64("late_rdy_ok",  {62'h0, i_data_ok, d_data_ok}, Z64);
        check64("late_rdy_mv",  {62'h0, m_valid, busy}, Z64);
        tick();
        check64("late_rdy_ok2", {62'h0, i_data_ok, d_data_ok}, Z64);
        check64("late_rdy_id",  {32'h0, i_data}, Z64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
